// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 LED panel row scan controller.
// Shifts one row of columns, blanks, latches, displays for on_time cycles, then advances the scan row.
module hub75_scan_ctrl #(
  parameter int COLS         = 64,
  parameter int HALF_ROWS    = 32,
  parameter int BLANK_CYCLES = 2,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(HALF_ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [15:0]   on_time,
  output logic [CW-1:0] col,
  output logic [RW-1:0] scan_row,
  output logic          rd_en,
  output logic          data_strobe,
  output logic          panel_clk,
  output logic          panel_lat,
  output logic          panel_oe_n,
  output logic [RW-1:0] addr_out,
  output logic          frame_done,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, SHIFT, TAIL, BLANK_PRE, LATCH, DISPLAY, BLANK_POST
  } state_t;

  localparam logic [15:0]   BLANK_LOAD = 16'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(HALF_ROWS - 1);

  state_t        state_q, state_d;
  logic          ph_q, ph_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rd_en_q, rd_en_d;
  logic          data_strobe_q, data_strobe_d;
  logic          panel_clk_q, panel_clk_d;
  logic          panel_lat_q, panel_lat_d;
  logic          panel_oe_n_q, panel_oe_n_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  // cnt_q holds the cycles remaining in the current blank/display phase after this one.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          ph_d    = 1'b0;
          col_d   = '0;
        end
      end
      SHIFT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (col_q == LAST_COL) state_d = TAIL;
          else                   col_d   = col_q + 1'b1;
        end
      end
      TAIL: begin
        state_d = BLANK_PRE;
        cnt_d   = BLANK_LOAD;
      end
      BLANK_PRE: begin
        if (cnt_q == '0) begin
          state_d = LATCH;
          cnt_d   = on_time;
          addr_d  = row_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      LATCH, DISPLAY: begin
        if (cnt_q == '0) begin
          state_d = BLANK_POST;
          cnt_d   = BLANK_LOAD;
        end else begin
          state_d = DISPLAY;
          cnt_d   = cnt_q - 16'd1;
        end
      end
      BLANK_POST: begin
        if (cnt_q == '0) begin
          row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
          col_d   = '0;
          ph_d    = 1'b0;
          state_d = enable ? SHIFT : IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin is a flop aligned with its state.
  always_comb begin
    rd_en_d       = (state_d == SHIFT) && !ph_d;
    data_strobe_d = (state_d == SHIFT) && ph_d;
    panel_clk_d   = ((state_d == SHIFT) && !ph_d && (col_d != '0)) || (state_d == TAIL);
    panel_lat_d   = (state_d == LATCH);
    panel_oe_n_d  = (state_d != DISPLAY);
    busy_d        = (state_d != IDLE);
    frame_done_d  = (row_q == LAST_ROW) && (cnt_d == '0) &&
                    ((state_d == LATCH) || (state_d == DISPLAY));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ph_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      rd_en_q       <= 1'b0;
      data_strobe_q <= 1'b0;
      panel_clk_q   <= 1'b0;
      panel_lat_q   <= 1'b0;
      panel_oe_n_q  <= 1'b1;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      col_q         <= col_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      rd_en_q       <= rd_en_d;
      data_strobe_q <= data_strobe_d;
      panel_clk_q   <= panel_clk_d;
      panel_lat_q   <= panel_lat_d;
      panel_oe_n_q  <= panel_oe_n_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign col         = col_q;
  assign scan_row    = row_q;
  assign addr_out    = addr_q;
  assign rd_en       = rd_en_q;
  assign data_strobe = data_strobe_q;
  assign panel_clk   = panel_clk_q;
  assign panel_lat   = panel_lat_q;
  assign panel_oe_n  = panel_oe_n_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule
